// File: rtl/rom_arb_pkg.sv
// Shared constants, FSM state type and the 16x4 lookup table for rom_lookup_arbiter.
package rom_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } state_t;

  // Entry k lives in bits [4k+3:4k]; entry 0 is the rightmost nibble.
  localparam logic [63:0] ROM_TABLE = 64'h6ae8_d31f_0c17_a92c;

  function automatic logic [DATA_W-1:0] rom_value(input logic [ADDR_W-1:0] a);
    return ROM_TABLE[{a, 2'b00} +: DATA_W];
  endfunction

endpackage

// File: rtl/rom_16x4_sync.sv
// Single-port synchronous-read ROM holding the package lookup table.
module rom_16x4_sync
  import rom_arb_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    q <= rom_value(addr);
  end

endmodule

// File: rtl/rom_lookup_arbiter.sv
// Two-requester req/ack arbiter in front of the shared 16x4 lookup ROM.
// Round-robin by default; define ROM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module rom_lookup_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              grant_id
);

  import rom_arb_pkg::state_t;
  import rom_arb_pkg::IDLE;
  import rom_arb_pkg::READ;
  import rom_arb_pkg::RESP;

  state_t            state;
  state_t            state_next;
  logic              winner;
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;

`ifdef ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = ~req[0];
  end
`else
  logic last_grant;

  always_comb begin
    if (req == 2'b11) winner = ~last_grant;
    else              winner = req[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        last_grant <= 1'b1;
    else if (state == IDLE && |req)    last_grant <= winner;
  end
`endif

  assign win_addr = winner ? addr1 : addr0;
  // ROM sees the winner's address during the grant cycle so its registered
  // output is already valid while in READ; data then captures it on READ exit.
  assign rom_addr = (state == IDLE) ? win_addr : addr_q;

  rom_16x4_sync u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .q    (rom_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = READ;
      READ:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= '0;
      data     <= '0;
      grant_id <= 1'b0;
      addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= winner;
            addr_q   <= win_addr;
          end
        end
        READ: begin
          data <= rom_q;
          ack  <= grant_id ? 2'b10 : 2'b01;
        end
        RESP:    ack <= '0;
        default: ack <= '0;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rom_lookup_arbiter.sv
// Scoreboard bench for rom_lookup_arbiter: randomized requests against a table/arbitration model.
module tb_rom_lookup_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] addr0;
  logic [3:0] addr1;
  logic [1:0] ack;
  logic [3:0] data;
  logic       busy;
  logic       grant_id;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [3:0]  data;
    logic        gid;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];

  logic [3:0] tbl [16] = '{4'hc, 4'h2, 4'h9, 4'ha, 4'h7, 4'h1, 4'hc, 4'h0,
                           4'hf, 4'h1, 4'h3, 4'hd, 4'h8, 4'he, 4'ha, 4'h6};
  int unsigned model_last = 1;

  rom_lookup_arbiter #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr0    (addr0),
    .addr1    (addr1),
    .ack      (ack),
    .data     (data),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned pick(input logic [1:0] r);
    if (r == 2'b11) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (model_last == 0) ? 1 : 0;
`endif
    end
    return (r == 2'b01) ? 0 : 1;
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge back in IDLE.
  // mode 0: inputs held; mode 1: addresses zeroed during READ; mode 2: inputs randomized after grant.
  task automatic issue(input logic [1:0] r, input logic [3:0] a0, input logic [3:0] a1, input int mode);
    exp_t e;
    int unsigned w;
    req = r; addr0 = a0; addr1 = a1;
    w = pick(r);
    model_last = w;
    e.ack  = (w == 0) ? 2'b01 : 2'b10;
    e.data = tbl[(w == 0) ? a0 : a1];
    e.gid  = w[0];
    e.cyc  = cyc + 2;
    sb.push_back(e);
    @(negedge clk);
    chk("busy_read", busy, 1);
    if (mode == 1) begin addr0 = 4'h0; addr1 = 4'h0; end
    if (mode == 2) begin req = 2'($urandom); addr0 = 4'($urandom); addr1 = 4'($urandom); end
    @(negedge clk);
    chk("busy_resp", busy, 1);
    if (mode == 2) begin req = 2'($urandom); addr0 = 4'($urandom); addr1 = 4'($urandom); end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 2'b00;
    repeat (n) begin
      @(negedge clk);
      chk("busy_idle", busy, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00;
    model_last = 1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ack !== 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=%b required=none (cycle %0d)", ack, cyc);
      end else begin
        e = sb.pop_front();
        chk("ack", ack, e.ack);
        chk("data", data, e.data);
        chk("grant_id", grant_id, e.gid);
        chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req = 2'b00; addr0 = 4'h0; addr1 = 4'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    idle(3);

    // single request
    issue(2'b01, 4'h8, 4'h0, 0);
    idle(2);

    // tie after reset: 0,1,0
    do_reset();
    issue(2'b11, 4'h3, 4'hd, 0);
    issue(2'b11, 4'h3, 4'hd, 0);
    issue(2'b11, 4'h3, 4'hd, 0);
    idle(1);

    // address change after grant is ignored
    issue(2'b10, 4'h0, 4'he, 1);
    idle(1);

    // reset during READ aborts the lookup
    req = 2'b01; addr0 = 4'h5;
    @(negedge clk);
    rst_n = 1'b0;
    model_last = 1;
    #1;
    check_reset_outputs("midrst");
    req = 2'b00;
    repeat (3) @(negedge clk);
    chk("midrst_busy_hold", busy, 0);
    rst_n = 1'b1;
    idle(2);
    issue(2'b01, 4'h5, 4'h0, 0);
    idle(1);

    // requester 1 sweeps the whole table
    for (int i = 0; i < 16; i++) issue(2'b10, 4'($urandom), 4'(i), 0);
    idle(1);

    // randomized traffic with input disturbance during service
    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(3);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
